// File: rtl/mux8_1_case.sv
// Registered 8-to-1 selector with a valid flag that travels alongside the data.
// One clock of latency, one selection per clock, no path from inputs to outputs.
module mux8_1_case #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic             valid_in,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       s_q,
  output logic             valid_out
);

  logic [WIDTH-1:0] sel_data;

  // Default covers an unknown select so the decode never holds state.
  always_comb begin
    sel_data = d0;
    case (s)
      3'd0:    sel_data = d0;
      3'd1:    sel_data = d1;
      3'd2:    sel_data = d2;
      3'd3:    sel_data = d3;
      3'd4:    sel_data = d4;
      3'd5:    sel_data = d5;
      3'd6:    sel_data = d6;
      3'd7:    sel_data = d7;
      default: sel_data = d0;
    endcase
  end

  // Data and select hold while idle; only the flag drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      s_q       <= 3'b000;
      valid_out <= 1'b0;
    end else if (valid_in) begin
      y         <= sel_data;
      s_q       <= s;
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8_1_case.sv
// Directed bench for mux8_1_case: select sweep, wrap, reset, hold,
// data independence and mid-cycle select changes.
module tb_mux8_1_case;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst;
  logic [2:0]       s;
  logic [WIDTH-1:0] d [8];
  logic             valid_in;
  logic [WIDTH-1:0] y;
  logic [2:0]       s_q;
  logic             valid_out;

  int passed;
  int total;

  mux8_1_case #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s),
    .d0        (d[0]),
    .d1        (d[1]),
    .d2        (d[2]),
    .d3        (d[3]),
    .d4        (d[4]),
    .d5        (d[5]),
    .d6        (d[6]),
    .d7        (d[7]),
    .valid_in  (valid_in),
    .y         (y),
    .s_q       (s_q),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d_index();
    for (int k = 0; k < 8; k++) d[k] = 3'(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b1;
    s = 3'd6;
    set_d_index();
    step();
    total++;
    if (y !== 3'b000 || s_q !== 3'b000 || valid_out !== 1'b0)
      $display("FAIL reset_init: y=%b s_q=%b vo=%b want 000 000 0",
               y, s_q, valid_out);
    else passed++;
    rst = 1'b0;
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    set_d_index();
    valid_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      step();
      total++;
      if (y !== 3'(k) || s_q !== 3'(k) || valid_out !== 1'b1)
        $display("FAIL sweep_%0d: y=%b s_q=%b vo=%b want %b %b 1",
                 k, y, s_q, valid_out, 3'(k), 3'(k));
      else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] wide;
    wide = 4'd8;
    s = wide[2:0];
    valid_in = 1'b1;
    step();
    total++;
    if (y !== 3'b000 || s_q !== 3'b000 || valid_out !== 1'b1)
      $display("FAIL wrap: y=%b s_q=%b vo=%b want 000 000 1",
               y, s_q, valid_out);
    else passed++;
  endtask

  task automatic test_reset_priority();
    s = 3'd5;
    d[5] = 3'b101;
    valid_in = 1'b1;
    step();
    rst = 1'b1;
    s = 3'd6;
    step();
    total++;
    if (y !== 3'b000 || s_q !== 3'b000 || valid_out !== 1'b0)
      $display("FAIL reset_prio: y=%b s_q=%b vo=%b want 000 000 0",
               y, s_q, valid_out);
    else passed++;
    rst = 1'b0;
    s = 3'd5;
    step();
    total++;
    if (y !== 3'b101 || s_q !== 3'd5 || valid_out !== 1'b1)
      $display("FAIL reset_release: y=%b s_q=%b vo=%b want 101 101 1",
               y, s_q, valid_out);
    else passed++;
  endtask

  task automatic test_hold();
    set_d_index();
    s = 3'd3;
    valid_in = 1'b1;
    step();
    total++;
    if (y !== 3'b011 || s_q !== 3'd3)
      $display("FAIL hold_cap: y=%b s_q=%b want 011 011", y, s_q);
    else passed++;
    valid_in = 1'b0;
    s = 3'd6;
    d[3] = 3'b111;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (y !== 3'b011 || s_q !== 3'd3 || valid_out !== 1'b0)
        $display("FAIL hold_%0d: y=%b s_q=%b vo=%b want 011 011 0",
                 k, y, s_q, valid_out);
      else passed++;
    end
  endtask

  task automatic test_data_indep();
    for (int k = 0; k < 8; k++) d[k] = 3'b111;
    d[4] = 3'b000;
    valid_in = 1'b1;
    s = 3'd4;
    step();
    total++;
    if (y !== 3'b000 || s_q !== 3'd4)
      $display("FAIL data_d4: y=%b s_q=%b want 000 100", y, s_q);
    else passed++;
    s = 3'd2;
    step();
    total++;
    if (y !== 3'b111 || s_q !== 3'd2)
      $display("FAIL data_d2: y=%b s_q=%b want 111 010", y, s_q);
    else passed++;
  endtask

  task automatic test_glitch();
    set_d_index();
    d[7] = 3'b110;
    valid_in = 1'b1;
    s = 3'd1;
    step();
    total++;
    if (y !== 3'b001 || s_q !== 3'd1)
      $display("FAIL glitch_pre: y=%b s_q=%b want 001 001", y, s_q);
    else passed++;
    s = 3'd7;
    #1 s = 3'd2;
    #1 s = 3'd0;
    #1 s = 3'd7;
    #2;
    total++;
    if (y !== 3'b001 || s_q !== 3'd1)
      $display("FAIL glitch_mid: y=%b s_q=%b want 001 001", y, s_q);
    else passed++;
    step();
    total++;
    if (y !== 3'b110 || s_q !== 3'd7 || valid_out !== 1'b1)
      $display("FAIL glitch_edge: y=%b s_q=%b vo=%b want 110 111 1",
               y, s_q, valid_out);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b0;
    valid_in = 1'b0;
    s = 3'd0;
    set_d_index();
    test_reset();
    test_sweep();
    test_wrap();
    test_reset_priority();
    test_hold();
    test_data_indep();
    test_glitch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
